// File: rtl/usb_ctl_pkg.sv
// -----------------------------------------------------------------------------
// usb_ctl_pkg
// Shared definitions for the USB control-request router: router state
// encoding, bmRequestType[6:5] request-type codes, common widths and the
// port-eligibility rule used when offering a setup request to the functions.
// Ports: none (package).
// -----------------------------------------------------------------------------
package usb_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STALL  = 2'd3
    } ctl_state_e;

    // bmRequestType[6:5] codes
    localparam logic [1:0] REQ_STD    = 2'd0;
    localparam logic [1:0] REQ_CLASS  = 2'd1;
    localparam logic [1:0] REQ_VENDOR = 2'd2;

    localparam int SEL_W = 3;
    localparam int CNT_W = 16;

    // Port 0 owns standard requests; everything else goes to ports 1..N-1.
    // A single-function router has nowhere else to send anything.
    function automatic logic port_eligible(input logic [1:0] req_type,
                                           input int         port,
                                           input int         num_funcs);
        logic elig;
        if (num_funcs == 1) begin
            elig = 1'b1;
        end else if (req_type == REQ_STD) begin
            elig = (port == 0);
        end else begin
            elig = (port != 0);
        end
        return elig;
    endfunction

endpackage

// File: rtl/usb_prio_enc.sv
// -----------------------------------------------------------------------------
// usb_prio_enc
// Lowest-index priority encoder.
// Ports:
//   req_vec [WIDTH] in  - request vector
//   hit         out     - at least one request bit set
//   idx  [SEL_W] out    - index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module usb_prio_enc
    import usb_ctl_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] req_vec,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {SEL_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = req_vec[i] ? SEL_W'(i) : idx;
        end
    end

    assign hit = |req_vec;

endmodule

// File: rtl/usb_ctl_router.sv
// -----------------------------------------------------------------------------
// usb_ctl_router
// Routes a USB control transfer to one of NUM_FUNCS control functions.
// A setup request is offered to the eligible functions; the lowest-index
// eligible function that grants owns the transfer and its IN/OUT data streams
// are muxed to/from the transfer layer. No grant within TIMEOUT offer cycles
// stalls the request. Dropping ctl_req_i always returns to idle.
// Ports:
//   clock, reset_n                 - clock, async active-low reset
//   ctl_req_i, ctl_type_i          - setup request level and bmRequestType
//   ctl_gnt_o/done_o/stall_o       - transfer status to the transfer layer
//   ctl_tvalid_o/tlast_o/tdata_o,
//   ctl_tready_i                   - IN stream to the transfer layer
//   ctl_rvalid_i, ctl_rdata_i      - OUT stream from the transfer layer
//   fn_req_o, fn_gnt_i, fn_done_i  - per-function request handshake
//   fn_tvalid_i/tlast_i/tdata_i,
//   fn_tready_o                    - per-function IN streams
//   fn_rvalid_o, fn_rdata_o        - per-function OUT valid, broadcast data
//   sel_o                          - selected function while ctl_gnt_o is high
// -----------------------------------------------------------------------------
module usb_ctl_router
    import usb_ctl_pkg::*;
#(
    parameter int NUM_FUNCS = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ctl_req_i,
    input  logic [7:0]             ctl_type_i,
    output logic                   ctl_gnt_o,
    output logic                   ctl_done_o,
    output logic                   ctl_stall_o,
    output logic                   ctl_tvalid_o,
    output logic                   ctl_tlast_o,
    output logic [7:0]             ctl_tdata_o,
    input  logic                   ctl_tready_i,
    input  logic                   ctl_rvalid_i,
    input  logic [7:0]             ctl_rdata_i,
    output logic [NUM_FUNCS-1:0]   fn_req_o,
    input  logic [NUM_FUNCS-1:0]   fn_gnt_i,
    input  logic [NUM_FUNCS-1:0]   fn_done_i,
    input  logic [NUM_FUNCS-1:0]   fn_tvalid_i,
    input  logic [NUM_FUNCS-1:0]   fn_tlast_i,
    input  logic [8*NUM_FUNCS-1:0] fn_tdata_i,
    output logic [NUM_FUNCS-1:0]   fn_tready_o,
    output logic [NUM_FUNCS-1:0]   fn_rvalid_o,
    output logic [7:0]             fn_rdata_o,
    output logic [SEL_W-1:0]       sel_o
);

    // Offer cycles are counted from 0, so the last allowed one is TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ctl_state_e           state_r;
    ctl_state_e           state_nxt_s;
    logic [1:0]           type_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [SEL_W-1:0]     sel_r;
    logic [NUM_FUNCS-1:0] elig_s;
    logic [NUM_FUNCS-1:0] gnt_elig_s;
    logic [NUM_FUNCS-1:0] sel_onehot_s;
    logic                 gnt_hit_s;
    logic [SEL_W-1:0]     gnt_idx_s;
    logic                 timeout_hit_s;
    logic                 unused_type_s;

    // Only bmRequestType[6:5] steers routing.
    assign unused_type_s = ^{ctl_type_i[7], ctl_type_i[4:0]};

    // Eligible ports for the latched request type.
    always_comb begin
        elig_s = {NUM_FUNCS{1'b0}};
        for (int i = 0; i < NUM_FUNCS; i++) begin
            elig_s[i] = port_eligible(type_r, i, NUM_FUNCS);
        end
    end

    // Decode of the registered selection.
    always_comb begin
        sel_onehot_s = {NUM_FUNCS{1'b0}};
        for (int i = 0; i < NUM_FUNCS; i++) begin
            sel_onehot_s[i] = (SEL_W'(i) == sel_r);
        end
    end

    // Grants from ineligible ports are masked before arbitration.
    assign gnt_elig_s    = fn_gnt_i & elig_s;
    assign timeout_hit_s = (cnt_r >= CNT_LAST);

    usb_prio_enc #(
        .WIDTH (NUM_FUNCS)
    ) u_prio_enc (
        .req_vec (gnt_elig_s),
        .hit     (gnt_hit_s),
        .idx     (gnt_idx_s)
    );

    // Next-state logic; request withdrawal beats everything, grant beats timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ctl_req_i) begin
                    state_nxt_s = ST_OFFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (!ctl_req_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (gnt_hit_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            ST_ACTIVE, ST_STALL: begin
                if (!ctl_req_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request type latch, saturating offer counter and winner capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            type_r <= 2'd0;
            cnt_r  <= {CNT_W{1'b0}};
            sel_r  <= {SEL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctl_req_i) begin
                        type_r <= ctl_type_i[6:5];
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_OFFER: begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                    if (ctl_req_i && gnt_hit_s) begin
                        sel_r <= gnt_idx_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output decode: all zero outside the states that drive them; the data
    // path through the selected function is combinational.
    always_comb begin
        ctl_gnt_o    = 1'b0;
        ctl_done_o   = 1'b0;
        ctl_stall_o  = 1'b0;
        ctl_tvalid_o = 1'b0;
        ctl_tlast_o  = 1'b0;
        ctl_tdata_o  = 8'h00;
        fn_req_o     = {NUM_FUNCS{1'b0}};
        fn_tready_o  = {NUM_FUNCS{1'b0}};
        fn_rvalid_o  = {NUM_FUNCS{1'b0}};
        sel_o        = {SEL_W{1'b0}};
        case (state_r)
            ST_OFFER: begin
                fn_req_o = elig_s;
            end
            ST_ACTIVE: begin
                ctl_gnt_o    = 1'b1;
                sel_o        = sel_r;
                fn_req_o     = sel_onehot_s;
                ctl_done_o   = |(fn_done_i & sel_onehot_s);
                ctl_tvalid_o = |(fn_tvalid_i & sel_onehot_s);
                ctl_tlast_o  = |(fn_tlast_i & sel_onehot_s);
                fn_tready_o  = sel_onehot_s & {NUM_FUNCS{ctl_tready_i}};
                fn_rvalid_o  = sel_onehot_s & {NUM_FUNCS{ctl_rvalid_i}};
                for (int i = 0; i < NUM_FUNCS; i++) begin
                    ctl_tdata_o = sel_onehot_s[i] ? fn_tdata_i[i*8 +: 8] : ctl_tdata_o;
                end
            end
            ST_STALL: begin
                ctl_stall_o = 1'b1;
                ctl_done_o  = 1'b1;
            end
            default: begin
                ctl_gnt_o = 1'b0;
            end
        endcase
    end

    assign fn_rdata_o = ctl_rdata_i;

endmodule

// File: tb/tb_usb_ctl_router.sv
// -----------------------------------------------------------------------------
// tb_usb_ctl_router
// Self-checking bench for usb_ctl_router (NUM_FUNCS=3, TIMEOUT=8).
// -----------------------------------------------------------------------------
module tb_usb_ctl_router;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic         clock;
    logic         reset_n;
    logic         ctl_req_i;
    logic [7:0]   ctl_type_i;
    logic         ctl_gnt_o;
    logic         ctl_done_o;
    logic         ctl_stall_o;
    logic         ctl_tvalid_o;
    logic         ctl_tlast_o;
    logic [7:0]   ctl_tdata_o;
    logic         ctl_tready_i;
    logic         ctl_rvalid_i;
    logic [7:0]   ctl_rdata_i;
    logic [N-1:0] fn_req_o;
    logic [N-1:0] fn_gnt_i;
    logic [N-1:0] fn_done_i;
    logic [N-1:0] fn_tvalid_i;
    logic [N-1:0] fn_tlast_i;
    logic [8*N-1:0] fn_tdata_i;
    logic [N-1:0] fn_tready_o;
    logic [N-1:0] fn_rvalid_o;
    logic [7:0]   fn_rdata_o;
    logic [2:0]   sel_o;

    int n_cmp = 0;
    int n_err = 0;

    usb_ctl_router #(
        .NUM_FUNCS (N),
        .TIMEOUT   (TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ctl_req_i    (ctl_req_i),
        .ctl_type_i   (ctl_type_i),
        .ctl_gnt_o    (ctl_gnt_o),
        .ctl_done_o   (ctl_done_o),
        .ctl_stall_o  (ctl_stall_o),
        .ctl_tvalid_o (ctl_tvalid_o),
        .ctl_tlast_o  (ctl_tlast_o),
        .ctl_tdata_o  (ctl_tdata_o),
        .ctl_tready_i (ctl_tready_i),
        .ctl_rvalid_i (ctl_rvalid_i),
        .ctl_rdata_i  (ctl_rdata_i),
        .fn_req_o     (fn_req_o),
        .fn_gnt_i     (fn_gnt_i),
        .fn_done_i    (fn_done_i),
        .fn_tvalid_i  (fn_tvalid_i),
        .fn_tlast_i   (fn_tlast_i),
        .fn_tdata_i   (fn_tdata_i),
        .fn_tready_o  (fn_tready_o),
        .fn_rvalid_o  (fn_rvalid_o),
        .fn_rdata_o   (fn_rdata_o),
        .sel_o        (sel_o)
    );

    // Every output flattened, for "everything reads zero" checks.
    logic [32:0] all_outs;
    assign all_outs = {ctl_gnt_o, ctl_done_o, ctl_stall_o, ctl_tvalid_o, ctl_tlast_o,
                       ctl_tdata_o, fn_req_o, fn_tready_o, fn_rvalid_o, fn_rdata_o, sel_o};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference rules: standard requests belong to port 0, the rest to 1..N-1.
    function automatic logic [N-1:0] ref_elig(input logic [7:0] bm_type);
        return (bm_type[6:5] == 2'd0) ? 3'b001 : 3'b110;
    endfunction

    // Lowest eligible granting port, -1 when nobody eligible grants.
    function automatic int ref_winner(input logic [7:0] bm_type, input logic [N-1:0] gnts);
        logic [N-1:0] m;
        m = ref_elig(bm_type) & gnts;
        for (int i = 0; i < N; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        ctl_req_i    = 1'b0;
        ctl_type_i   = 8'h00;
        ctl_tready_i = 1'b0;
        ctl_rvalid_i = 1'b0;
        ctl_rdata_i  = 8'h00;
        fn_gnt_i     = '0;
        fn_done_i    = '0;
        fn_tvalid_i  = '0;
        fn_tlast_i   = '0;
        fn_tdata_i   = '0;
    endtask

    // Withdraw the request and let the router settle back in idle.
    task automatic release_req();
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (all_outs !== 33'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", all_outs);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        n_cmp++;
        if (all_outs !== 33'd0) begin
            n_err++;
            $display("FAIL reset_release_idle got=%h want=0", all_outs);
        end
    endtask

    task automatic test_get_descriptor();
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h80;
        @(negedge clock); #1;
        n_cmp++;
        if (fn_req_o !== 3'b001 || ctl_gnt_o !== 1'b0) begin
            n_err++;
            $display("FAIL gd_offer fn_req=%b gnt=%b want fn_req=001 gnt=0", fn_req_o, ctl_gnt_o);
        end
        @(negedge clock);
        fn_gnt_i = 3'b001;
        @(negedge clock);
        fn_tvalid_i  = 3'b111;
        fn_tdata_i   = 24'hEEDD12;
        ctl_tready_i = 1'b1;
        #1;
        n_cmp++;
        if (ctl_gnt_o !== 1'b1 || sel_o !== 3'd0 || ctl_tdata_o !== 8'h12 || ctl_tvalid_o !== 1'b1 ||
            ctl_tlast_o !== 1'b0 || fn_tready_o !== 3'b001 || ctl_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL gd_byte0 gnt=%b sel=%0d data=%h valid=%b last=%b tready=%b done=%b want 1 0 12 1 0 001 0",
                     ctl_gnt_o, sel_o, ctl_tdata_o, ctl_tvalid_o, ctl_tlast_o, fn_tready_o, ctl_done_o);
        end
        @(negedge clock);
        fn_tdata_i = 24'h776601;
        fn_tlast_i = 3'b001;
        fn_done_i  = 3'b001;
        #1;
        n_cmp++;
        if (ctl_tdata_o !== 8'h01 || ctl_tlast_o !== 1'b1 || ctl_done_o !== 1'b1) begin
            n_err++;
            $display("FAIL gd_byte1 data=%h last=%b done=%b want 01 1 1", ctl_tdata_o, ctl_tlast_o, ctl_done_o);
        end
        @(negedge clock);
        fn_done_i = 3'b110;
        #1;
        n_cmp++;
        if (ctl_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL gd_done_follow done=%b want 0", ctl_done_o);
        end
        release_req();
    endtask

    task automatic test_vendor_tie();
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h40;
        @(negedge clock);
        fn_gnt_i = 3'b110;
        #1;
        n_cmp++;
        if (fn_req_o !== 3'b110) begin
            n_err++;
            $display("FAIL vt_offer fn_req=%b want 110", fn_req_o);
        end
        for (int j = 0; j < 4; j++) begin
            logic [7:0] d1;
            logic [7:0] d2;
            @(negedge clock);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            fn_tdata_i   = {d2, d1, 8'h3C};
            fn_tvalid_i  = 3'b110;
            ctl_tready_i = 1'b1;
            #1;
            n_cmp++;
            if (sel_o !== 3'd1 || fn_tready_o !== 3'b010 || ctl_tdata_o !== d1 || fn_req_o !== 3'b010) begin
                n_err++;
                $display("FAIL vt_active sel=%0d tready=%b data=%h req=%b want 1 010 %h 010",
                         sel_o, fn_tready_o, ctl_tdata_o, fn_req_o, d1);
            end
        end
        release_req();
    endtask

    task automatic test_class_timeout();
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h21;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock); #1;
            n_cmp++;
            if (ctl_stall_o !== (k >= TMO + 1) || ctl_gnt_o !== 1'b0 ||
                fn_req_o !== ((k >= TMO + 1) ? 3'b000 : 3'b110) || ctl_done_o !== (k >= TMO + 1)) begin
                n_err++;
                $display("FAIL ct_cycle k=%0d stall=%b done=%b req=%b gnt=%b", k, ctl_stall_o, ctl_done_o,
                         fn_req_o, ctl_gnt_o);
            end
        end
        @(negedge clock);
        ctl_req_i = 1'b0;
        @(negedge clock); #1;
        n_cmp++;
        if (all_outs !== 33'd0) begin
            n_err++;
            $display("FAIL ct_idle got=%h want=0", all_outs);
        end
    endtask

    task automatic test_out_phase();
        int pulses;
        pulses = 0;
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'hC1;
        @(negedge clock);
        fn_gnt_i = 3'b100;
        for (int j = 0; j < 8; j++) begin
            logic       rv;
            logic [7:0] rd;
            @(negedge clock);
            rv = (j % 2 == 0);
            rd = 8'hAA + 8'(j / 2);
            ctl_rvalid_i = rv;
            ctl_rdata_i  = rd;
            #1;
            if (fn_rvalid_o[2] === 1'b1) pulses++;
            n_cmp++;
            if (fn_rvalid_o !== {rv, 2'b00} || fn_rdata_o !== rd || sel_o !== 3'd2) begin
                n_err++;
                $display("FAIL op_beat j=%0d rvalid=%b rdata=%h sel=%0d want %b %h 2", j, fn_rvalid_o,
                         fn_rdata_o, sel_o, {rv, 2'b00}, rd);
            end
        end
        n_cmp++;
        if (pulses != 4) begin
            n_err++;
            $display("FAIL op_pulses got=%0d want=4", pulses);
        end
        release_req();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h80;
        fn_gnt_i   = 3'b001;
        @(negedge clock);
        @(negedge clock);
        fn_tvalid_i  = 3'b001;
        fn_tdata_i   = 24'h0000A5;
        ctl_tready_i = 1'b1;
        fn_done_i    = 3'b001;
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outs !== 33'd0) begin
            n_err++;
            $display("FAIL rm_async got=%h want=0", all_outs);
        end
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b1;
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h40;
        @(negedge clock);
        fn_gnt_i = 3'b010;
        #1;
        n_cmp++;
        if (fn_req_o !== 3'b110 || ctl_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_reoffer req=%b done=%b want 110 0", fn_req_o, ctl_done_o);
        end
        @(negedge clock); #1;
        n_cmp++;
        if (ctl_gnt_o !== 1'b1 || sel_o !== 3'd1) begin
            n_err++;
            $display("FAIL rm_regrant gnt=%b sel=%0d want 1 1", ctl_gnt_o, sel_o);
        end
        release_req();
    endtask

    task automatic test_port0_vendor();
        @(negedge clock);
        ctl_req_i  = 1'b1;
        ctl_type_i = 8'h40;
        fn_gnt_i   = 3'b001;
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clock); #1;
            n_cmp++;
            if (ctl_gnt_o !== 1'b0 || ctl_stall_o !== (k == TMO + 1)) begin
                n_err++;
                $display("FAIL p0v_cycle k=%0d gnt=%b stall=%b", k, ctl_gnt_o, ctl_stall_o);
            end
        end
        release_req();
    endtask

    // Random requests: the expected phase of each cycle follows from when the
    // grant appears and whether an eligible port is in it.
    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [7:0]   bm;
            logic [N-1:0] gmask;
            int           g;
            int           w;
            int           act_from;
            int           stall_from;
            bm    = 8'($urandom);
            gmask = 3'($urandom);
            g     = $urandom_range(0, 10);
            w     = ref_winner(bm, gmask);
            act_from   = (w >= 0 && g < TMO) ? g + 2 : 99;
            stall_from = (act_from == 99) ? TMO + 1 : 99;
            @(negedge clock);
            ctl_req_i  = 1'b1;
            ctl_type_i = bm;
            for (int k = 1; k <= 12; k++) begin
                logic [32:0]  exp_v;
                logic [N-1:0] e_req;
                logic [N-1:0] e_trdy;
                logic [N-1:0] e_rv;
                logic [7:0]   e_data;
                logic [23:0]  td;
                logic         act;
                logic         stl;
                @(negedge clock);
                fn_gnt_i     = (k >= g + 1) ? gmask : 3'b000;
                fn_done_i    = 3'($urandom);
                fn_tvalid_i  = 3'($urandom);
                fn_tlast_i   = 3'($urandom);
                td           = 24'($urandom);
                fn_tdata_i   = td;
                ctl_tready_i = 1'($urandom);
                ctl_rvalid_i = 1'($urandom);
                ctl_rdata_i  = 8'($urandom);
                act = (k >= act_from);
                stl = !act && (k >= stall_from);
                if (act) begin
                    e_req  = 3'(1 << w);
                    e_trdy = ctl_tready_i ? e_req : 3'b000;
                    e_rv   = ctl_rvalid_i ? e_req : 3'b000;
                    e_data = 8'(td >> (8 * w));
                    exp_v  = {1'b1, fn_done_i[w], 1'b0, fn_tvalid_i[w], fn_tlast_i[w], e_data,
                              e_req, e_trdy, e_rv, ctl_rdata_i, 3'(w)};
                end else begin
                    e_req = stl ? 3'b000 : ref_elig(bm);
                    exp_v = {1'b0, stl, stl, 1'b0, 1'b0, 8'h00, e_req, 3'b000, 3'b000,
                             ctl_rdata_i, 3'd0};
                end
                #1;
                n_cmp++;
                if (all_outs !== exp_v) begin
                    n_err++;
                    $display("FAIL random_cycle it=%0d k=%0d type=%h gnts=%b g=%0d got=%h want=%h",
                             it, k, bm, gmask, g, all_outs, exp_v);
                end
            end
            @(negedge clock);
            clear_inputs();
            @(negedge clock); #1;
            n_cmp++;
            if (all_outs !== 33'd0) begin
                n_err++;
                $display("FAIL random_idle it=%0d got=%h want=0", it, all_outs);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_get_descriptor();
        test_vendor_tie();
        test_class_timeout();
        test_out_phase();
        test_reset_mid();
        test_port0_vendor();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
